// File: rtl/mux_2to1_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_2to1_arbiter
// Brief    : Two-source burst arbiter feeding a registered 2:1 output stage.
// Revision : 1.0 - initial release
// ============================================================================
module mux_2to1_arbiter #(
    parameter int DW        = 2,
    parameter int MAX_BEATS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in0_valid,
    input  logic [DW-1:0] in0_data,
    input  logic          in0_last,
    output logic          in0_ready,
    input  logic          in1_valid,
    input  logic [DW-1:0] in1_data,
    input  logic          in1_last,
    output logic          in1_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          out_src,
    input  logic          out_ready,
    output logic          sel
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    localparam logic [7:0] c_max_beats = 8'(MAX_BEATS);

    state_t        r_state;
    state_t        w_next_state;
    logic          r_prio;
    logic [7:0]    r_beat_cnt;
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic          r_out_last;
    logic          r_out_src;
    logic          r_sel;

    logic          w_slot_free;
    logic          w_ready0;
    logic          w_ready1;
    logic          w_acc0;
    logic          w_acc1;
    logic          w_acc;
    logic          w_acc_last;
    logic [DW-1:0] w_acc_data;
    logic [7:0]    w_cnt_next;
    logic          w_release;

    // The output slot can take a new beat when empty or being drained this cycle.
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_ready0    = (r_state == ST_GRANT0) && w_slot_free;
    assign w_ready1    = (r_state == ST_GRANT1) && w_slot_free;
    assign w_acc0      = in0_valid && w_ready0;
    assign w_acc1      = in1_valid && w_ready1;
    assign w_acc       = w_acc0 || w_acc1;
    assign w_acc_last  = w_acc1 ? in1_last : in0_last;
    assign w_acc_data  = w_acc1 ? in1_data : in0_data;
    assign w_cnt_next  = r_beat_cnt + 8'd1;
    assign w_release   = w_acc && (w_acc_last || (w_cnt_next == c_max_beats));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in0_valid && in1_valid)
                    w_next_state = r_prio ? ST_GRANT1 : ST_GRANT0;
                else if (in0_valid)
                    w_next_state = ST_GRANT0;
                else if (in1_valid)
                    w_next_state = ST_GRANT1;
            end
            ST_GRANT0: begin
                if (w_release)
                    w_next_state = in1_valid ? ST_GRANT1 : ST_IDLE;
            end
            ST_GRANT1: begin
                if (w_release)
                    w_next_state = in0_valid ? ST_GRANT0 : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_prio      <= 1'b0;
            r_beat_cnt  <= 8'd0;
            r_sel       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_sel   <= (w_next_state == ST_GRANT1);

            // Every release changes state, so a state change marks a fresh grant.
            if (w_next_state != r_state)
                r_beat_cnt <= 8'd0;
            else if (w_acc)
                r_beat_cnt <= w_cnt_next;

            if (w_release)
                r_prio <= !w_acc1;

            if (w_acc) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_acc_data;
                r_out_last  <= w_acc_last;
                r_out_src   <= w_acc1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in0_ready = w_ready0;
    assign in1_ready = w_ready1;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;
    assign sel       = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux_2to1_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_2to1_arbiter
// Brief    : Scoreboard bench for mux_2to1_arbiter with directed bursts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_2to1_arbiter;

    localparam int DW        = 2;
    localparam int MAX_BEATS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in0_valid, in0_last, in0_ready;
    logic          in1_valid, in1_last, in1_ready;
    logic [DW-1:0] in0_data, in1_data;
    logic          out_valid, out_last, out_src, out_ready, sel;
    logic [DW-1:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected beat packed as {src, last, data}.
    logic [DW+1:0] sb[$];

    mux_2to1_arbiter #(.DW(DW), .MAX_BEATS(MAX_BEATS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
        .out_ready(out_ready), .sel(sel)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push(logic src, logic last, logic [DW-1:0] data);
        sb.push_back({src, last, data});
    endfunction

    // Monitor: every output handshake is compared with the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got src=%0d data=%0h with empty queue", out_src, out_data);
            end else begin
                logic [DW+1:0] e;
                e = sb.pop_front();
                chk("sb_beat", {out_src, out_last, out_data}, e);
            end
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        in0_valid = 1'b1; in0_data = 2'd3; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 2'd3; in1_last = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_out_src",   out_src,   0);
        chk("rst_sel",       sel,       0);
        chk("rst_ready",     {in0_ready, in1_ready}, 0);
        in0_valid = 1'b0; in1_valid = 1'b0; in0_last = 1'b0; in1_last = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Presents n beats on source s, each held until accepted.
    task automatic drive_src(input bit s, input int n, input logic [15:0] d, input logic [7:0] l);
        for (int i = 0; i < n; i++) begin
            int  waited;
            bit  acc;
            if (!s) begin in0_valid = 1'b1; in0_data = d[2*i +: 2]; in0_last = l[i]; end
            else    begin in1_valid = 1'b1; in1_data = d[2*i +: 2]; in1_last = l[i]; end
            waited = 0;
            acc    = 1'b0;
            while (!acc && waited < 200) begin
                @(negedge clk);
                acc = s ? (in1_valid && in1_ready) : (in0_valid && in0_ready);
                waited++;
            end
            if (!acc) begin
                chk("drive_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
        if (!s) begin in0_valid = 1'b0; in0_last = 1'b0; end
        else    begin in1_valid = 1'b0; in1_last = 1'b0; end
    endtask

    task automatic wait_neg(input string name, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            case (name)
                "first_ready":  ok = in0_ready || in1_ready;
                "src0_last":    ok = out_valid && out_last && !out_src;
                "acc1":         ok = in1_valid && in1_ready;
                "out_valid":    ok = out_valid;
                default:        ok = 1'b0;
            endcase
        end
        if (!ok) chk({"timeout_", name}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;

        // Simultaneous requests after reset, source0 burst, then direct handover.
        do_reset();
        push(1'b0, 1'b0, 2'd1);
        push(1'b0, 1'b1, 2'd3);
        push(1'b1, 1'b1, 2'd2);
        fork
            drive_src(1'b0, 2, 16'h000D, 8'h02);
            drive_src(1'b1, 1, 16'h0002, 8'h01);
            begin
                wait_neg("first_ready", 20, ok);
                if (ok) begin
                    chk("s1_first_grant_ready", {in0_ready, in1_ready}, 2'b10);
                    chk("s1_first_grant_sel", sel, 0);
                end
                wait_neg("src0_last", 20, ok);
                if (ok) begin
                    chk("s1_handover_sel", sel, 1);
                    chk("s1_handover_ready1", in1_ready, 1);
                end
            end
        join
        repeat (3) @(posedge clk);
        chk("s1_sb_empty", sb.size(), 0);

        // Source1 six beats without last: four-beat cap, IDLE, re-grant.
        do_reset();
        push(1'b1, 1'b0, 2'd1); push(1'b1, 1'b0, 2'd2); push(1'b1, 1'b0, 2'd3);
        push(1'b1, 1'b0, 2'd0); push(1'b1, 1'b0, 2'd1); push(1'b1, 1'b0, 2'd2);
        fork
            drive_src(1'b1, 6, 16'h0939, 8'h00);
            begin
                for (int a = 0; a < 4; a++) wait_neg("acc1", 20, ok);
                @(negedge clk);
                chk("s2_release_ready1", in1_ready, 0);
                chk("s2_release_idle_sel", sel, 0);
                @(negedge clk);
                chk("s2_regrant_sel", sel, 1);
                chk("s2_regrant_ready1", in1_ready, 1);
            end
        join
        repeat (3) @(posedge clk);
        chk("s2_sb_empty", sb.size(), 0);

        // Output backpressure for three cycles, then gap-free drain.
        do_reset();
        push(1'b0, 1'b0, 2'd1); push(1'b0, 1'b0, 2'd2);
        push(1'b0, 1'b0, 2'd3); push(1'b0, 1'b1, 2'd0);
        fork
            drive_src(1'b0, 4, 16'h0039, 8'h08);
            begin
                ok = 1'b0;
                for (int k = 0; k < 20 && !ok; k++) begin
                    @(posedge clk); #1;
                    ok = out_valid;
                end
                if (!ok) chk("timeout_s3_out_valid", 0, 1);
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("s3_stall_data", out_data, 1);
                    chk("s3_stall_valid", out_valid, 1);
                    chk("s3_stall_ready0", in0_ready, 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("s3_no_bubble", out_valid, 1);
                end
            end
        join
        repeat (3) @(posedge clk);
        chk("s3_sb_empty", sb.size(), 0);

        // Reset mid-burst with a beat held in GRANT1.
        do_reset();
        out_ready = 1'b0;
        in1_valid = 1'b1; in1_data = 2'd2; in1_last = 1'b0;
        wait_neg("out_valid", 20, ok);
        chk("s4_pre_sel", sel, 1);
        chk("s4_pre_src", out_src, 1);
        rst_n = 1'b0;
        #1;
        chk("s4_async_valid", out_valid, 0);
        chk("s4_async_data",  out_data,  0);
        chk("s4_async_src",   out_src,   0);
        chk("s4_async_sel",   sel,       0);
        chk("s4_async_ready", {in0_ready, in1_ready}, 0);
        in1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        in0_valid = 1'b1; in0_data = 2'd1; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 2'd1; in1_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("s4_after_reset_sel", sel, 0);
        chk("s4_after_reset_ready", {in0_ready, in1_ready}, 2'b10);
        in0_valid = 1'b0; in1_valid = 1'b0;
        repeat (2) @(posedge clk);
        chk("s4_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_2to1_arbiter.md
MUX_2TO1_ARBITER -- requirements
Module: mux_2to1_arbiter

Interface
REQ-001 Parameter: DW, default 2, width of each source data word and of the output word.
REQ-002 Parameter: MAX_BEATS, default 4, maximum beats one source may send per grant (range 1..255).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset; deassertion is synchronised externally.
REQ-005 in0_valid, in1_valid  input  1 each  source beat available.
REQ-006 in0_data, in1_data  input  DW each  source beat data.
REQ-007 in0_last, in1_last  input  1 each  beat ends the source's burst.
REQ-008 in0_ready, in1_ready  output  1 each  beat accepted this cycle when valid and ready are both high.
REQ-009 out_valid  output  1  registered output beat present.
REQ-010 out_data  output  DW  registered beat data.
REQ-011 out_last  output  1  registered copy of the accepted beat's last flag.
REQ-012 out_src  output  1  source index (0/1) of the beat in the output register.
REQ-013 out_ready  input  1  downstream accepts the output beat when out_valid and out_ready are both high.
REQ-014 sel  output  1  select for the shared 2:1 data mux; registered, equals current grant (0 in IDLE).

Function
REQ-015 FSM states: IDLE, GRANT0, GRANT1; sel = 1 only in GRANT1.
REQ-016 IDLE: both valid -> grant the source indicated by priority pointer prio; one valid -> grant that source; none -> stay IDLE; transition takes one cycle, with no acceptance in IDLE.
REQ-017 inN_ready = (state == GRANTN) && (!out_valid || out_ready); the other source's ready is 0.
REQ-018 Accepted beat loads out_data, out_last, out_src on the same edge; out_valid rises one cycle after acceptance (latency 1).
REQ-019 Output register holds data stable while out_valid && !out_ready; it clears out_valid on a handshake with no new accepted beat.
REQ-020 Simultaneous output handshake and new acceptance in the same cycle: the register is reloaded, out_valid stays 1, and there is no bubble.
REQ-021 beat_cnt (8-bit) clears on entry to a GRANT state and increments on each accepted beat.
REQ-022 Grant release occurs on an accepted beat with last = 1, or with beat_cnt + 1 == MAX_BEATS, whichever comes first.
REQ-023 On release from GRANTN: prio := other source; if the other source's valid is high in the release cycle -> go directly to GRANT(other); otherwise -> IDLE.
REQ-024 A source dropping valid mid-burst keeps the grant; it waits indefinitely, with no timeout.
REQ-025 A MAX_BEATS release does not modify out_last; the remainder of the burst re-arbitrates as a new grant.

Reset
REQ-026 While rst_n = 0: state = IDLE, prio = 0, beat_cnt = 0, out_valid = 0, out_data = 0, out_last = 0, out_src = 0, sel = 0, in0_ready = in1_ready = 0.
REQ-027 Reset assertion mid-burst aborts immediately; the held output beat is discarded, and the first grant after reset follows REQ-016 with prio = 0.

Verification
REQ-028 Reset, then in0_valid and in1_valid both 1 from the same cycle, out_ready = 1 -> GRANT0 first, sel = 0; the first out_valid shows out_src = 0.
REQ-029 Source0 sends a 2-beat burst (data 1, 3; last on beat 2) while source1 is valid -> out_data = 1, 3 on consecutive cycles; the state then goes directly to GRANT1 and sel = 1 on the cycle after the last acceptance.
REQ-030 Source1 holds valid with last = 0 for 6 beats, MAX_BEATS = 4 -> exactly 4 beats accepted, then release; with source0 idle the FSM goes to IDLE and then re-grants source1 for the remaining 2 beats.
REQ-031 out_ready held 0 for 3 cycles with a beat in the register -> out_data is stable, the granted inN_ready = 0, and no beat is lost; on out_ready = 1, back-to-back transfer resumes with no bubble.
REQ-032 rst_n pulsed low mid-burst (out_valid = 1, state GRANT1) -> all outputs are at reset values in the same cycle; after release, both valid -> GRANT0.
